// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter
// Round-robin arbiter sharing one downstream resource among 8 requesters.
// The winner is the first active request found searching downward from the
// priority pointer (ptr, ptr-1, ..., wrapping mod 8). Grants are registered
// and held until the owner drops its request or the hold limit expires.
// After every release the pointer moves to one below the released owner, so
// that owner becomes the lowest priority for the next arbitration.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no grant; arbitrate on the next edge if any request is set
// ST_BUSY | grant held by own_q; hcnt_q counts cycles the grant has lasted

module rr_priority_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       valid,
  output logic       timeout
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Hold-limit compare value; MAX_HOLD is confined to 1..255.
  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  logic [0:0] state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] own_q, own_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;

  logic [2:0] win_idx;
  logic       win_found;
  logic [2:0] cand;

  // Rotating priority search: candidates scanned from lowest priority
  // (ptr+1) up to highest (ptr); the last hit is the winner.
  always_comb begin
    win_idx   = 3'd0;
    win_found = 1'b0;
    cand      = 3'd0;
    for (int j = 0; j < 8; j++) begin
      cand = ptr_q + 3'd1 + 3'(j);
      if (req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // Next-state logic for the grant FSM, pointer, owner and hold counter.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    own_d     = own_q;
    hcnt_d    = hcnt_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant_d = 8'd0;
        idx_d   = 3'd0;
        valid_d = 1'b0;
        if (win_found) begin
          state_d = ST_BUSY;
          own_d   = win_idx;
          grant_d = 8'd1 << win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
          hcnt_d  = 8'd1;
        end
      end

      ST_BUSY: begin
        // An owner dropping its request on the limit cycle counts as a
        // normal release, so the request check takes precedence.
        if (!req[own_q] || (hcnt_q == MAX_HOLD_C)) begin
          state_d   = ST_IDLE;
          ptr_d     = own_q - 3'd1;
          hcnt_d    = 8'd0;
          grant_d   = 8'd0;
          idx_d     = 3'd0;
          valid_d   = 1'b0;
          timeout_d = req[own_q];
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = 8'd0;
        idx_d   = 3'd0;
        valid_d = 1'b0;
        hcnt_d  = 8'd0;
      end
    endcase
  end

  // State and output registers; reset restores the fixed-priority origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 3'd7;
      own_q     <= 3'd0;
      hcnt_q    <= 8'd0;
      grant_q   <= 8'd0;
      idx_q     <= 3'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      hcnt_q    <= hcnt_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Bench for rr_priority_arbiter: two instances (MAX_HOLD 16 and 4) share
// req/rst_n and are compared every cycle against a behavioural model.

module tb_rr_priority_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;

  logic [7:0] g16, g4;
  logic [2:0] i16, i4;
  logic       v16, v4, t16, t4;

  int checks   = 0;
  int failures = 0;

  rr_priority_arbiter #(.MAX_HOLD(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(g16), .grant_idx(i16), .valid(v16), .timeout(t16)
  );

  rr_priority_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(g4), .grant_idx(i4), .valid(v4), .timeout(t4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per instance, who holds the resource and for how long.
  int m_busy [2];
  int m_ptr  [2];
  int m_own  [2];
  int m_len  [2];
  int m_to   [2];
  int m_max  [2] = '{16, 4};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_ptr[k] = 7; m_own[k] = 0; m_len[k] = 0; m_to[k] = 0;
    end
  endtask

  task automatic model_step(input logic [7:0] r);
    for (int k = 0; k < 2; k++) begin
      m_to[k] = 0;
      if (m_busy[k] == 0) begin
        for (int i = 0; i < 8; i++) begin
          int c;
          c = (m_ptr[k] - i + 8) % 8;
          if (r[c] && m_busy[k] == 0) begin
            m_busy[k] = 1; m_own[k] = c; m_len[k] = 1;
          end
        end
      end else if (r[m_own[k]] == 1'b0) begin
        m_busy[k] = 0; m_ptr[k] = (m_own[k] + 7) % 8;
      end else if (m_len[k] == m_max[k]) begin
        m_busy[k] = 0; m_ptr[k] = (m_own[k] + 7) % 8; m_to[k] = 1;
      end else begin
        m_len[k] = m_len[k] + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("g16", 32'(g16), m_busy[0] != 0 ? (32'd1 << m_own[0]) : 32'd0);
    chk("i16", 32'(i16), m_busy[0] != 0 ? 32'(m_own[0]) : 32'd0);
    chk("v16", 32'(v16), 32'(m_busy[0] != 0));
    chk("t16", 32'(t16), 32'(m_to[0]));
    chk("g4",  32'(g4),  m_busy[1] != 0 ? (32'd1 << m_own[1]) : 32'd0);
    chk("i4",  32'(i4),  m_busy[1] != 0 ? 32'(m_own[1]) : 32'd0);
    chk("v4",  32'(v4),  32'(m_busy[1] != 0));
    chk("t4",  32'(t4),  32'(m_to[1]));
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(req);
    else model_reset();
    @(negedge clk);
    chk_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int seen7;

  initial begin
    rst_n = 1'b1;
    req   = 8'd0;
    model_reset();

    // Reset and idle
    do_reset();
    for (int n = 0; n < 5; n++) tick();
    chk("idle_grant", 32'(g16), 32'd0);

    // 00100100: winner 5, then 2 after one idle cycle
    req = 8'b0010_0100;
    tick();
    chk("first_win_grant", 32'(g16), 32'h20);
    chk("first_win_idx", 32'(i16), 32'd5);
    tick();
    req = 8'b0000_0100;
    tick();
    chk("release_clear", 32'(v16), 32'd0);
    tick();
    chk("second_win_idx", 32'(i16), 32'd2);
    chk("second_win_grant", 32'(g16), 32'h04);

    // Wrap: release 2, grant 0, release 0, then 7 wins over 0
    req = 8'b0000_0000;
    tick();
    req = 8'b0000_0001;
    tick();
    chk("grant0_idx", 32'(i16), 32'd0);
    chk("grant0_valid", 32'(v16), 32'd1);
    req = 8'b0000_0000;
    tick();
    req = 8'b1000_0001;
    tick();
    chk("wrap_idx", 32'(i16), 32'd7);
    req = 8'b0000_0000;
    tick();

    // All requesting, held: rotation with timeouts on the MAX_HOLD=4 unit
    do_reset();
    req = 8'hFF;
    tick();
    chk("ff_first_idx", 32'(i4), 32'd7);
    for (int n = 0; n < 4; n++) tick();
    chk("ff_timeout4", 32'(t4), 32'd1);
    chk("ff_idle4", 32'(v4), 32'd0);
    tick();
    chk("ff_second_idx", 32'(i4), 32'd6);
    for (int n = 0; n < 40; n++) tick();
    req = 8'd0;
    tick();
    tick();

    // Single requester 3, held: re-granted after each forced idle cycle
    do_reset();
    req = 8'b0000_1000;
    for (int n = 0; n < 5; n++) tick();
    chk("solo_timeout", 32'(t4), 32'd1);
    tick();
    chk("solo_regrant", 32'(g4), 32'h08);
    chk("solo_no_pulse", 32'(t4), 32'd0);
    for (int n = 0; n < 24; n++) tick();
    chk("solo_long16_to", 32'(t16), 32'(m_to[0]));
    req = 8'd0;
    tick();
    tick();

    // Mid-grant reset
    do_reset();
    req = 8'b0100_0000;
    tick();
    chk("mid_pre_idx", 32'(i16), 32'd6);
    tick();
    req = 8'b0100_0010;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_grant", 32'(g16), 32'd0);
    chk("mid_rst_valid", 32'(v16), 32'd0);
    chk("mid_rst_timeout", 32'(t16), 32'd0);
    chk_model();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mid_after_idx", 32'(i16), 32'd6);

    // Randomised traffic against the model
    seen7 = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3, 0) == 0) begin
        if ($urandom_range(7, 0) == 0) req = 8'd0;
        else req = 8'($urandom);
      end
      tick();
    end
    req = 8'd0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rr_priority_arbiter.md
# rr_priority_arbiter

Round-robin arbiter that shares one downstream resource among 8 requesters. It uses the 8-to-3 priority encoding of our priority encoder: the highest-priority active bit wins and is reported as a 3-bit index plus a valid flag. Unlike the combinational encoder, the priority origin rotates after every grant, grants are registered and held, and a hold-time limit prevents one requester from starving the others. It sits between request sources and the shared datapath, and drives the datapath select from `grant_idx`.

## Interface
- `MAX_HOLD`, 16: maximum consecutive cycles a single grant may stay asserted. Legal range is 1..255.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input 8: request vector. Bit k high means requester k wants the resource. A requester keeps its bit high for as long as it uses the resource.
- `grant` output 8: one-hot grant, registered. All zeros when idle.
- `grant_idx` output 3: binary index of the granted requester. It reads 0 when `valid`=0.
- `valid` output 1: high while any grant is asserted (the analogue of the encoder's V).
- `timeout` output 1: one-cycle pulse when a grant is forcibly ended by `MAX_HOLD`.

## Operation
- Internal state:
  - FSM with states IDLE and BUSY.
  - Priority pointer `ptr` (3 bits).
  - Owner index `own` (3 bits).
  - Hold counter `hcnt` (8 bits).
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - `state`=IDLE, `ptr`=7, `own`=0, `hcnt`=0.
  - `grant`=0, `grant_idx`=0, `valid`=0, `timeout`=0.
- Search order from `ptr` is ptr, ptr-1, ..., 0, 7, ..., ptr+1, with mod-8 wrap. With ptr=7 this is identical to the fixed priority encoder (bit 7 highest).
- IDLE:
  - If req≠0 at a clock edge, the winner w is the first set bit in search order.
  - State goes to BUSY, `own`=w, `grant`=1<<w, `grant_idx`=w, `valid`=1, `hcnt`=1.
  - If req=0, stay in IDLE with all outputs 0.
- BUSY, evaluated at each edge:
  - Normal release: req[own]=0. State goes to IDLE, grant/valid/grant_idx clear, `ptr`=own-1 mod 8 (own=0 gives ptr=7).
  - Forced release: req[own]=1 and hcnt=MAX_HOLD. Same as normal release, and `timeout` is set for exactly one cycle.
  - Otherwise the grant holds and `hcnt` increments.
- Other requests, including a new higher-priority bit, never preempt a held grant.
- After a release, IDLE lasts at least one cycle, so there is always at least one all-zero grant cycle between two grants.
- A requester that timed out still competes at lowest priority. If it is the only requester, it is re-granted after the one idle cycle.
- `grant` is always one-hot or zero. `grant_idx` and `grant` always agree.

## Timing
- Grant latency:
  - req is sampled at edge E. Grant is visible in the cycle after E.
  - From IDLE with a request present in cycle c, grant is asserted in cycle c+1.
- Release latency:
  - req[own] is low in cycle c; grant is still high in c and low from c+1.
  - The next grant appears no earlier than c+2.
- Maximum grant length is MAX_HOLD cycles. The `timeout` pulse coincides with the first idle cycle after a forced release.
- Simultaneous events:
  - Owner drops its req in the same cycle that hcnt=MAX_HOLD: treated as a normal release, no timeout.
  - Changes to req in the BUSY state on bits other than `own` are ignored until IDLE.
- Reset mid-grant: outputs go to 0 asynchronously, with no timeout pulse. The first edge after rst_n rises arbitrates with ptr=7.

## Test plan
- After reset, hold req=8'b00000000 for 5 cycles -> grant=0, grant_idx=0, valid=0, timeout=0 throughout.
- Reset, then req=8'b00100100 held:
  - Winner is 5 (grant=8'b00100000, idx=5) one cycle later.
  - Drop bit 5: grant clears the next cycle, one idle cycle follows, then grant=8'b00000100 (idx=2), with ptr=4.
- Wrap-around: after a grant to idx 0 is released, req=8'b10000001 -> grant idx 7 (ptr wrapped to 7).
- MAX_HOLD=4, req=8'hFF held:
  - Grant order is 7,6,5,4,3,2,1,0,7, each for 4 cycles.
  - Each grant is followed by 1 idle cycle with timeout=1.
  - valid is low only on those idle cycles.
- MAX_HOLD=4, req=8'b00001000 held: idx 3 is granted 4 cycles, then 1 idle cycle with timeout pulse, and the pattern repeats indefinitely.
- Mid-grant reset: while idx 6 is granted, pull rst_n low between edges -> grant/valid drop immediately. Release with req=8'b01000010 -> idx 6 is granted (ptr=7 restored).
